// File: rtl/player_input_controller.sv
// Per-player input front end: synchronises raw keys, rate-limits movement
// to one step per tick, edge-detects bomb presses with a tick-based
// cooldown, and defers all strobes while the draw pipeline is busy.
module player_input_controller #(
  parameter int MOVE_PERIOD   = 6250000,
  parameter int BOMB_COOLDOWN = 16,
  parameter int CNT_W         = 23
) (
  input  logic clock,
  input  logic reset_n,
  input  logic enable,
  input  logic hold,
  input  logic key_up,
  input  logic key_down,
  input  logic key_left,
  input  logic key_right,
  input  logic key_bomb,
  output logic xmov,
  output logic xdir,
  output logic ymov,
  output logic ydir,
  output logic bomb,
  output logic tick
);

  localparam int CD_W = (BOMB_COOLDOWN > 0) ? $clog2(BOMB_COOLDOWN + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MOVE_PERIOD - 1);
  localparam logic [CD_W-1:0]  CD_LOAD  = CD_W'(BOMB_COOLDOWN);

  typedef struct packed {
    logic bomb;
    logic up;
    logic down;
    logic left;
    logic right;
  } keys_t;

  // Axis that produced the most recent diagonal step.
  typedef enum logic {AX_X = 1'b0, AX_Y = 1'b1} axis_e;

  keys_t key_raw, key_s1, key_s;

  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CD_W-1:0]  cd, cd_n;
  logic             mv_pend, mv_pend_n;
  logic             bomb_pend, bomb_pend_n;
  logic             bomb_prev;
  axis_e            last_axis, last_axis_n;
  logic             tick_n, xmov_n, xdir_n, ymov_n, ydir_n, bomb_n;

  logic x_req, y_req, pick_x, mv_issue;
  logic bomb_edge, bomb_accept, bomb_issue;

  assign key_raw = '{bomb: key_bomb, up: key_up, down: key_down,
                     left: key_left, right: key_right};

  // Two-flop synchroniser on every raw key level.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      key_s1 <= '0;
      key_s  <= '0;
    end else begin
      key_s1 <= key_raw;
      key_s  <= key_s1;
    end
  end

  // State and registered strobe outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt       <= '0;
      cd        <= '0;
      mv_pend   <= 1'b0;
      bomb_pend <= 1'b0;
      bomb_prev <= 1'b0;
      last_axis <= AX_X;
      tick      <= 1'b0;
      xmov      <= 1'b0;
      xdir      <= 1'b0;
      ymov      <= 1'b0;
      ydir      <= 1'b0;
      bomb      <= 1'b0;
    end else begin
      cnt       <= cnt_n;
      cd        <= cd_n;
      mv_pend   <= mv_pend_n;
      bomb_pend <= bomb_pend_n;
      bomb_prev <= key_s.bomb;
      last_axis <= last_axis_n;
      tick      <= tick_n;
      xmov      <= xmov_n;
      xdir      <= xdir_n;
      ymov      <= ymov_n;
      ydir      <= ydir_n;
      bomb      <= bomb_n;
    end
  end

  // Next-state and strobe decisions. A tick or a fresh bomb edge counts as
  // pending in the same cycle, so an unheld request issues without an extra
  // cycle of latency.
  always_comb begin
    cnt_n       = '0;
    tick_n      = 1'b0;
    mv_pend_n   = mv_pend;
    bomb_pend_n = bomb_pend;
    cd_n        = cd;
    last_axis_n = last_axis;

    if (enable) cnt_n = (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
    // Registered so that the tick output lines up with cnt == MOVE_PERIOD-1.
    tick_n = enable && (cnt_n == CNT_LAST);

    // Opposite keys on one axis cancel that axis.
    x_req  = key_s.left ^ key_s.right;
    y_req  = key_s.up ^ key_s.down;
    // With both axes requested, step the axis not used last time.
    pick_x = x_req && (!y_req || last_axis == AX_Y);

    mv_issue = enable && !hold && (mv_pend || tick);
    if (tick)     mv_pend_n = 1'b1;
    if (mv_issue) mv_pend_n = 1'b0;
    if (mv_issue && x_req && y_req) last_axis_n = pick_x ? AX_X : AX_Y;

    bomb_edge   = key_s.bomb && !bomb_prev;
    bomb_accept = enable && bomb_edge && (cd == '0) && !bomb_pend;
    bomb_issue  = enable && !hold && (bomb_pend || bomb_accept);
    if (bomb_accept) bomb_pend_n = 1'b1;
    if (bomb_issue)  bomb_pend_n = 1'b0;

    if (tick && cd != '0) cd_n = cd - 1'b1;
    if (bomb_issue)       cd_n = CD_LOAD;

    // Game inactive: drop everything except the diagonal alternation.
    if (!enable) begin
      mv_pend_n   = 1'b0;
      bomb_pend_n = 1'b0;
      cd_n        = '0;
    end

    xmov_n = mv_issue && pick_x;
    xdir_n = xmov_n && key_s.right;
    ymov_n = mv_issue && y_req && !pick_x;
    ydir_n = ymov_n && key_s.down;
    bomb_n = bomb_issue;
  end

endmodule

// File: tb/tb_player_input_controller.sv
// Directed bench for player_input_controller with MOVE_PERIOD=4,
// BOMB_COOLDOWN=3. A per-cycle vector table covers idle, single-axis,
// cancelling, diagonal, hold, bomb cooldown and enable-drop behaviour;
// hand sequences cover asynchronous reset and combined move+bomb release.
module tb_player_input_controller;

  logic clock = 1'b0;
  logic reset_n, enable, hold;
  logic key_up, key_down, key_left, key_right, key_bomb;
  logic xmov, xdir, ymov, ydir, bomb, tick;
  logic [5:0] obs;

  int checks = 0;
  int errors = 0;

  localparam logic [4:0] K_R = 5'b00001, K_L = 5'b00010, K_D = 5'b00100,
                         K_U = 5'b01000, K_B = 5'b10000;
  localparam logic [5:0] E_TK = 6'b100000, E_XM = 6'b010000, E_XD = 6'b001000,
                         E_YM = 6'b000100, E_YD = 6'b000010, E_BM = 6'b000001;
  localparam logic [5:0] NO_TICK = 6'b011111;
  localparam int NV = 98;

  typedef struct {
    logic       en;
    logic       hold;
    logic [4:0] keys;
    logic [5:0] exp;
  } vec_t;

  vec_t tbl [1:NV];

  player_input_controller #(
    .MOVE_PERIOD(4), .BOMB_COOLDOWN(3), .CNT_W(2)
  ) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .hold(hold),
    .key_up(key_up), .key_down(key_down), .key_left(key_left),
    .key_right(key_right), .key_bomb(key_bomb),
    .xmov(xmov), .xdir(xdir), .ymov(ymov), .ydir(ydir),
    .bomb(bomb), .tick(tick)
  );

  always #5 clock = ~clock;

  assign obs = {tick, xmov, xdir, ymov, ydir, bomb};

  task automatic drive(input logic en, input logic hd, input logic [4:0] k);
    enable = en;
    hold   = hd;
    {key_bomb, key_up, key_down, key_left, key_right} = k;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [5:0] got, input logic [5:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got tick/xm/xd/ym/yd/bm=%b, expected %b", name, got, exp);
    end
  endtask

  task automatic fill(input int a, input int b, input logic en, input logic hd,
                      input logic [4:0] k);
    for (int i = a; i <= b; i++) begin
      tbl[i].en   = en;
      tbl[i].hold = hd;
      tbl[i].keys = k;
      tbl[i].exp  = '0;
    end
  endtask

  initial begin
    // Row k holds the inputs applied before edge k and the outputs expected
    // just after it, counting edges from reset release.
    fill( 1,  8, 1'b1, 1'b0, 5'b0);
    fill( 9, 16, 1'b1, 1'b0, K_R);
    fill(17, 24, 1'b1, 1'b0, K_R | K_L);
    fill(25, 40, 1'b1, 1'b0, K_U | K_L);
    fill(41, 53, 1'b1, 1'b1, K_D);
    fill(54, 60, 1'b1, 1'b0, 5'b0);
    fill(61, 64, 1'b1, 1'b0, K_B);
    fill(65, 66, 1'b1, 1'b0, 5'b0);
    fill(67, 70, 1'b1, 1'b0, K_B);
    fill(71, 74, 1'b1, 1'b0, 5'b0);
    fill(75, 90, 1'b1, 1'b0, K_B);
    fill(91, 92, 1'b1, 1'b1, K_R);
    fill(93, 94, 1'b0, 1'b0, K_R);
    fill(95, 98, 1'b1, 1'b0, K_R);

    for (int k = 3; k <= 91; k += 4) tbl[k].exp |= E_TK;
    tbl[97].exp |= E_TK;
    tbl[12].exp |= E_XM | E_XD;   // right, synced by 10, tick at 11
    tbl[16].exp |= E_XM | E_XD;
    tbl[28].exp |= E_YM;          // diagonal up-left starts on Y
    tbl[32].exp |= E_XM;
    tbl[36].exp |= E_YM;
    tbl[40].exp |= E_XM;
    tbl[54].exp |= E_YM | E_YD;   // single deferred move when hold drops
    tbl[63].exp |= E_BM;          // press at 61, press at 67 inside cooldown
    tbl[77].exp |= E_BM;          // press at 75 after cooldown expired
    tbl[98].exp |= E_XM | E_XD;   // first tick 4 cycles into re-enable

    reset_n = 1'b0;
    drive(1'b1, 1'b0, 5'b0);
    repeat (3) step();
    check("reset_state", obs, 6'b0);
    reset_n = 1'b1;
    check("post_release", obs, 6'b0);

    for (int k = 1; k <= NV; k++) begin
      drive(tbl[k].en, tbl[k].hold, tbl[k].keys);
      step();
      check($sformatf("vec%0d", k), obs, tbl[k].exp);
    end

    // Bomb pending under hold, then reset while the tick output is high.
    drive(1'b1, 1'b1, K_B);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("hold_bomb%0d", i), obs & NO_TICK, 6'b0);
    end
    check("tick_before_reset", obs, E_TK);
    reset_n = 1'b0;
    drive(1'b1, 1'b0, 5'b0);
    #1;
    check("async_reset", obs, 6'b0);
    repeat (2) step();
    check("in_reset", obs, 6'b0);
    reset_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      check($sformatf("after_reset%0d", k), obs, (k % 4 == 3) ? E_TK : 6'b0);
    end

    // Move and bomb both pending under hold issue together on release.
    drive(1'b1, 1'b1, K_R | K_B);
    for (int k = 9; k <= 16; k++) begin
      step();
      check($sformatf("hold_both%0d", k), obs & NO_TICK, 6'b0);
    end
    drive(1'b1, 1'b0, K_R | K_B);
    step();
    check("release_both", obs, E_XM | E_XD | E_BM);
    step();
    check("after_both", obs, 6'b0);
    step();
    check("next_tick", obs, E_TK);
    step();
    check("next_move", obs, E_XM | E_XD);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/player_input_controller.md
Name: player_input_controller

Overview:
- Sits directly upstream of the game datapath and produces its per-player movement and bomb strobes (bomb, xdir, xmov, ydir, ymov).
- Converts raw, asynchronous key levels into rate-limited single-cycle move pulses and edge-triggered bomb pulses.
- One instance is built per player.
- Defers strobes while the draw pipeline is busy, so a coordinate never changes mid-draw.

Parameters:
- MOVE_PERIOD, 6250000, clock cycles between movement ticks (8 ticks/s at 50 MHz); minimum 2.
- BOMB_COOLDOWN, 16, number of movement ticks after a bomb pulse during which further bomb presses are discarded; 0 disables the cooldown.
- CNT_W, 23, width of the tick counter; must hold MOVE_PERIOD-1.

Ports:
- clock  input  1  system clock; single clock domain.
- reset_n  input  1  asynchronous, active-low reset.
- enable  input  1  game active; when low, all strobes are suppressed and state is cleared.
- hold  input  1  draw pipeline busy; pending strobes wait while high.
- key_up  input  1  raw level, active-high, asynchronous.
- key_down  input  1  raw level, active-high, asynchronous.
- key_left  input  1  raw level, active-high, asynchronous.
- key_right  input  1  raw level, active-high, asynchronous.
- key_bomb  input  1  raw level, active-high, asynchronous.
- xmov  output  1  one-cycle pulse: move on the X axis.
- xdir  output  1  1 = increase X (right), 0 = decrease X; valid when xmov=1, otherwise 0.
- ymov  output  1  one-cycle pulse: move on the Y axis.
- ydir  output  1  1 = increase Y (down), 0 = decrease Y; valid when ymov=1, otherwise 0.
- bomb  output  1  one-cycle pulse: place a bomb.
- tick  output  1  one-cycle pulse when the tick counter wraps; for debug and bench use.

Behaviour:

Reset:
- Asynchronous assertion clears all registers: counter=0, pending flags=0, last_axis=0 (X), cooldown=0, synchroniser flops=0.
- All outputs are 0 while reset is asserted and in the first cycle after release.

Synchronisation:
- Each key passes through a 2-flop synchroniser.
- A key change becomes visible 2 cycles later; decisions use the synchronised levels only.

Tick counter:
- Counts 0..MOVE_PERIOD-1 while enable=1 and wraps to 0.
- tick=1 in the cycle the counter equals MOVE_PERIOD-1.
- On tick, move_pending is set.
- Extra ticks while a move is already pending are absorbed; there is no queue deeper than 1.

Move issue:
- Condition: move_pending=1, hold=0, enable=1.
- Resolve each axis: left XOR right gives an X request, with xdir=right; up XOR down gives a Y request, with ydir=down. Opposite keys on an axis cancel that axis.
- Only X requested: xmov=1. Only Y requested: ymov=1.
- Both requested: pulse the axis opposite to last_axis, then update last_axis. Diagonal input therefore alternates X, Y, X, … on successive ticks.
- xmov and ymov are never high in the same cycle.
- move_pending is cleared in the issue cycle even when no axis is requested, so a key pressed after the tick waits for the next tick.

Bomb:
- A rising edge of synced key_bomb with cooldown=0 and enable=1 sets bomb_pending.
- Edges seen while cooldown>0 or bomb_pending=1 are discarded.
- Issue: when bomb_pending=1 and hold=0, bomb=1 for one cycle, bomb_pending is cleared, and cooldown is loaded with BOMB_COOLDOWN.
- Cooldown decrements by 1 on each tick until it reaches 0.
- The bomb and move pulses may coincide in the same cycle.

Hold:
- While hold=1, no xmov, ymov or bomb pulse is produced. Pending flags and the counter keep running.
- The first cycle with hold=0 issues whatever is pending: a move and a bomb together if both are pending.

Enable low:
- Counter, pending flags and cooldown are cleared synchronously; outputs are 0. last_axis is retained.
- When enable rises, the first tick occurs MOVE_PERIOD cycles later.

Mid-operation reset:
- Any reset_n low forces the reset state immediately, regardless of pending flags or hold.

Outputs:
- All outputs are registered, with a one-cycle latency from the issue condition being true.

Test Plan:
(Bench uses MOVE_PERIOD=4, BOMB_COOLDOWN=3.)
- Reset and idle: reset_n=0 then 1, enable=1, no keys -> tick every 4 cycles; xmov=ymov=bomb=0 throughout.
- Single direction: key_right held -> xmov=1 with xdir=1 once per tick (1 cycle after each tick); ymov stays 0. Add key_left -> no xmov while both are held.
- Diagonal: key_up+key_left held from reset -> the pulse sequence on successive ticks is ymov (ydir=0), xmov (xdir=0), ymov, xmov; xmov and ymov are never simultaneous.
- Hold deferral: key_down held, hold=1 across 3 ticks, then hold=0 -> exactly one ymov pulse (ydir=1) in the first cycle after hold falls.
- Bomb cooldown: press key_bomb -> bomb pulse about 3 cycles after the edge. A second press 1 tick later is discarded. A press after 3 further ticks yields a pulse. Holding the key gives only one pulse.
- Enable/reset mid-operation: enable drop while move_pending=1 -> no pulse, counter=0. reset_n low while bomb_pending=1 -> no bomb pulse after release, all outputs 0.
